// File: rtl/life_pkg.sv
// Shared HUD lives-bar definitions: transparency code, heart icon bitmap,
// FSM state type and the lives clamping helper.
package life_pkg;

    localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;
    localparam int HEART_W = 25;
    localparam int HEART_H = 25;
    localparam logic [7:0] HEART_COLOR = 8'hC0;

    typedef logic [0:HEART_H-1][0:HEART_W-1][7:0] heart_bmp_t;

    typedef enum logic {IDLE, BLINK} life_state_t;

    // Two round lobes over a downward-pointing triangle.
    function automatic heart_bmp_t build_heart();
        heart_bmp_t bmp;
        for (int r = 0; r < HEART_H; r++) begin
            for (int c = 0; c < HEART_W; c++) begin
                int dx1;
                int dx2;
                int dy;
                int hw;
                int ad;
                logic opaque;
                dx1 = c - 6;
                dx2 = c - 18;
                dy = r - 6;
                hw = ((24 - r) * 12) / 14;
                ad = (c > 12) ? c - 12 : 12 - c;
                opaque = (dx1 * dx1 + dy * dy <= 40) || (dx2 * dx2 + dy * dy <= 40) ||
                         ((r >= 6) && (ad <= hw));
                bmp[r][c] = opaque ? HEART_COLOR : TRANSPARENT_ENCODING;
            end
        end
        return bmp;
    endfunction

    localparam heart_bmp_t HEART_BITMAP = build_heart();

    function automatic logic [3:0] clamp_lives(input shortint v, input int max);
        if (v < 0) begin
            return 4'd0;
        end
        if (int'(v) > max) begin
            return max[3:0];
        end
        return v[3:0];
    endfunction

endpackage

// File: rtl/heart_bitmap_rom.sv
// Combinational heart icon ROM; returns transparent outside the icon bounds.
module heart_bitmap_rom
    import life_pkg::*;
(
    input  logic [4:0] row_i,
    input  logic [4:0] col_i,
    output logic [7:0] rgb_o
);

    always_comb begin
        rgb_o = TRANSPARENT_ENCODING;
        if ((int'(row_i) < HEART_H) && (int'(col_i) < HEART_W)) begin
            rgb_o = HEART_BITMAP[row_i][col_i];
        end
    end

endmodule

// File: rtl/life_bar_animated.sv
// Lives indicator: row of hearts, frame-synchronous updates, lost hearts
// blink before disappearing.
module life_bar_animated
    import life_pkg::*;
#(
    parameter int         TOP_LEFT_X   = 15,
    parameter int         TOP_LEFT_Y   = 15,
    parameter int         ICON_W       = 25,
    parameter int         ICON_H       = 25,
    parameter int         SPACING      = 2,
    parameter int         MAX_LIVES    = 5,
    parameter int         BLINK_FRAMES = 48,
    parameter int         BLINK_HALF   = 8,
    parameter bit         SHOW_EMPTY   = 1'b0,
    parameter logic [7:0] EMPTY_COLOR  = 8'h92
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [10:0]        pixel_x_i,
    input  logic [10:0]        pixel_y_i,
    input  logic               visible_i,
    input  logic               start_of_frame_i,
    input  logic signed [15:0] lives_i,
    output logic               drawing_request_o,
    output logic [7:0]         life_rgb_o,
    output logic               blinking_o,
    output logic [3:0]         lives_shown_o
);

    localparam int PITCH = ICON_W + SPACING;
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    localparam int HW = $clog2(BLINK_HALF + 1);

    life_state_t   state_q;
    logic [3:0]    shown_q;
    logic [3:0]    target_q;
    logic [FW-1:0] frame_cnt_q;
    logic [HW-1:0] half_cnt_q;
    logic          blink_on_q;
    logic [7:0]    rgb_q;
    logic [7:0]    rgb_d;
    logic [3:0]    l_val;

    assign l_val = clamp_lives(lives_i, MAX_LIVES);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            shown_q     <= 4'd0;
            target_q    <= 4'd0;
            frame_cnt_q <= '0;
            half_cnt_q  <= '0;
            blink_on_q  <= 1'b0;
        end else if (start_of_frame_i) begin
            case (state_q)
                IDLE: begin
                    if (l_val > shown_q) begin
                        shown_q <= l_val;
                    end else if (l_val < shown_q) begin
                        target_q    <= l_val;
                        frame_cnt_q <= FW'(BLINK_FRAMES);
                        half_cnt_q  <= HW'(BLINK_HALF);
                        blink_on_q  <= 1'b0;
                        state_q     <= BLINK;
                    end
                end
                BLINK: begin
                    if (l_val < target_q) begin
                        // Another heart lost mid-blink: widen the blinking range, restart timing.
                        target_q    <= l_val;
                        frame_cnt_q <= FW'(BLINK_FRAMES);
                        half_cnt_q  <= HW'(BLINK_HALF);
                        blink_on_q  <= 1'b0;
                    end else if (l_val > target_q) begin
                        shown_q <= l_val;
                        state_q <= IDLE;
                    end else begin
                        if (half_cnt_q == HW'(1)) begin
                            blink_on_q <= ~blink_on_q;
                            half_cnt_q <= HW'(BLINK_HALF);
                        end else begin
                            half_cnt_q <= half_cnt_q - HW'(1);
                        end
                        frame_cnt_q <= frame_cnt_q - FW'(1);
                        if (frame_cnt_q == FW'(1)) begin
                            shown_q <= target_q;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    int         off_x;
    int         off_y;
    int         slot;
    int         lx;
    logic [7:0] bmp;
    logic [7:0] empty_pix;
    logic       in_icon;

    assign off_x = int'({21'd0, pixel_x_i}) - TOP_LEFT_X;
    assign off_y = int'({21'd0, pixel_y_i}) - TOP_LEFT_Y;
    assign slot  = off_x / PITCH;
    assign lx    = off_x % PITCH;

    heart_bitmap_rom u_rom (
        .row_i (off_y[4:0]),
        .col_i (lx[4:0]),
        .rgb_o (bmp)
    );

    always_comb begin
        rgb_d     = TRANSPARENT_ENCODING;
        empty_pix = (SHOW_EMPTY && (bmp != TRANSPARENT_ENCODING)) ? EMPTY_COLOR
                                                                 : TRANSPARENT_ENCODING;
        in_icon   = visible_i && (off_x >= 0) && (off_y >= 0) && (off_y < ICON_H) &&
                    (slot < MAX_LIVES) && (lx < ICON_W);
        if (in_icon) begin
            if ((slot < int'(target_q)) || ((state_q == IDLE) && (slot < int'(shown_q)))) begin
                rgb_d = bmp;
            end else if ((state_q == BLINK) && (slot < int'(shown_q))) begin
                rgb_d = blink_on_q ? bmp : empty_pix;
            end else begin
                rgb_d = empty_pix;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rgb_q <= TRANSPARENT_ENCODING;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign life_rgb_o        = rgb_q;
    assign drawing_request_o = (rgb_q != TRANSPARENT_ENCODING);
    assign blinking_o        = (state_q == BLINK);
    assign lives_shown_o     = shown_q;

endmodule

// File: tb/tb_life_bar_animated.sv
// Directed bench: two instances (empty slots hidden / dimmed) share stimulus;
// pixel expectations go through a scoreboard queue.
module tb_life_bar_animated;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [10:0]        pixel_x = '0;
    logic [10:0]        pixel_y = '0;
    logic               visible = 1'b0;
    logic               sof = 1'b0;
    logic signed [15:0] lives = '0;

    logic       dreq_a, blink_a, dreq_b, blink_b;
    logic [7:0] rgb_a, rgb_b;
    logic [3:0] shown_a, shown_b;

    int passed = 0;
    int total = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    life_bar_animated u_dut_a (
        .clk_i             (clk),
        .reset_i           (reset),
        .pixel_x_i         (pixel_x),
        .pixel_y_i         (pixel_y),
        .visible_i         (visible),
        .start_of_frame_i  (sof),
        .lives_i           (lives),
        .drawing_request_o (dreq_a),
        .life_rgb_o        (rgb_a),
        .blinking_o        (blink_a),
        .lives_shown_o     (shown_a)
    );

    life_bar_animated #(.SHOW_EMPTY(1'b1)) u_dut_b (
        .clk_i             (clk),
        .reset_i           (reset),
        .pixel_x_i         (pixel_x),
        .pixel_y_i         (pixel_y),
        .visible_i         (visible),
        .start_of_frame_i  (sof),
        .lives_i           (lives),
        .drawing_request_o (dreq_b),
        .life_rgb_o        (rgb_b),
        .blinking_o        (blink_b),
        .lives_shown_o     (shown_b)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic frame(input int v);
        @(negedge clk);
        lives = 16'(v);
        sof = 1'b1;
        @(posedge clk);
        #1;
        sof = 1'b0;
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic vis,
                       input logic [7:0] ea, input logic [7:0] eb);
        logic [15:0] e;
        @(negedge clk);
        pixel_x = 11'(x);
        pixel_y = 11'(y);
        visible = vis;
        exp_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_rgb_a"}, {8'd0, rgb_a}, {8'd0, e[15:8]});
        chk({tag, "_rgb_b"}, {8'd0, rgb_b}, {8'd0, e[7:0]});
        chk({tag, "_dreq_a"}, {15'd0, dreq_a}, {15'd0, (e[15:8] != 8'hFF)});
        visible = 1'b0;
    endtask

    task automatic state(input string tag, input logic [3:0] shown, input logic blk);
        chk({tag, "_shown"}, {12'd0, shown_a}, {12'd0, shown});
        chk({tag, "_blinking"}, {15'd0, blink_a}, {15'd0, blk});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic on;
        // Reset values
        #12;
        chk("rst_rgb", {8'd0, rgb_a}, 16'h00FF);
        chk("rst_dreq", {15'd0, dreq_a}, 16'd0);
        state("rst", 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Basic drawing with 3 lives
        frame(3);
        state("up3", 4'd3, 1'b0);
        pix("slot0", 15, 25, 1'b1, 8'hC0, 8'hC0);
        pix("gap", 40, 25, 1'b1, 8'hFF, 8'hFF);
        pix("slot3_empty", 96, 25, 1'b1, 8'hFF, 8'h92);
        pix("left_of_bar", 14, 25, 1'b1, 8'hFF, 8'hFF);
        pix("below_bar", 15, 40, 1'b1, 8'hFF, 8'hFF);
        pix("invisible", 15, 25, 1'b0, 8'hFF, 8'hFF);

        // Lose one heart: slot 2 blinks with period 2*8 frames for 48 frames
        frame(2);
        state("blink_start", 4'd3, 1'b1);
        pix("blink_f0", 69, 25, 1'b1, 8'hFF, 8'h92);
        for (int k = 1; k <= 48; k++) begin
            frame(2);
            if (k < 48) begin
                on = ((k / 8) % 2) == 1;
                state("blink_k", 4'd3, 1'b1);
                pix("blink_slot2", 69, 25, 1'b1, on ? 8'hC0 : 8'hFF, on ? 8'hC0 : 8'h92);
            end
        end
        state("blink_done", 4'd2, 1'b0);
        pix("gone_slot2", 69, 25, 1'b1, 8'hFF, 8'h92);
        pix("empty_transp", 96, 15, 1'b1, 8'hFF, 8'hFF);
        pix("kept_slot1", 42, 25, 1'b1, 8'hC0, 8'hC0);

        // Second loss mid-blink widens the range and restarts timing
        frame(3);
        state("back3", 4'd3, 1'b0);
        frame(2);
        for (int k = 1; k <= 9; k++) frame(2);
        frame(0);
        state("reblink", 4'd3, 1'b1);
        pix("reblink_slot0", 15, 25, 1'b1, 8'hFF, 8'h92);
        for (int m = 1; m <= 48; m++) begin
            frame(0);
            if (m == 7) pix("reblink_m7", 15, 25, 1'b1, 8'hFF, 8'h92);
            if (m == 8) begin
                pix("reblink_m8_s0", 15, 25, 1'b1, 8'hC0, 8'hC0);
                pix("reblink_m8_s2", 69, 25, 1'b1, 8'hC0, 8'hC0);
            end
            if (m == 47) state("reblink_m47", 4'd3, 1'b1);
        end
        state("reblink_done", 4'd0, 1'b0);

        // Gain during blink aborts immediately
        frame(2);
        state("up2", 4'd2, 1'b0);
        frame(1);
        frame(1);
        frame(1);
        state("abort_pre", 4'd2, 1'b1);
        frame(4);
        state("abort", 4'd4, 1'b0);
        pix("abort_slot3", 96, 25, 1'b1, 8'hC0, 8'hC0);

        // Clamping
        frame(-5);
        state("neg_start", 4'd4, 1'b1);
        for (int k = 1; k <= 48; k++) frame(-5);
        state("neg_done", 4'd0, 1'b0);
        frame(20);
        state("clamp_hi", 4'd5, 1'b0);
        pix("slot4", 123, 25, 1'b1, 8'hC0, 8'hC0);
        pix("slot5_out", 150, 25, 1'b1, 8'hFF, 8'hFF);

        // Reset mid-blink
        frame(2);
        for (int k = 1; k <= 20; k++) frame(2);
        pix("pre_rst", 15, 25, 1'b1, 8'hC0, 8'hC0);
        @(negedge clk);
        pixel_x = 11'd15;
        pixel_y = 11'd25;
        visible = 1'b1;
        reset = 1'b1;
        #1;
        chk("midrst_rgb", {8'd0, rgb_a}, 16'h00FF);
        chk("midrst_dreq", {15'd0, dreq_a}, 16'd0);
        state("midrst", 4'd0, 1'b0);
        visible = 1'b0;
        frame(4);
        state("rst_sof_ignored", 4'd0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        frame(3);
        state("after_rst", 4'd3, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
